// File: rtl/datapath_wide.sv
// datapath_wide: accumulator datapath with a register file, single-cycle
// ALU/transfer ops and a two-phase FIM register-pair load from the data bus.
// Optional feature: define DATAPATH_DAA_EN to enable decimal adjust (op C);
// without it op C is a NOP that still pulses done.
module datapath_wide #(
    parameter int  DATA_W   = 4,
    parameter int  NUM_REGS = 16,
    localparam int RI_W     = $clog2(NUM_REGS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                op_valid,
    input  logic [3:0]          op,
    input  logic [RI_W-1:0]     operand,
    input  logic [DATA_W-1:0]   imm,
    input  logic [DATA_W-1:0]   data,
    input  logic                test,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   acc,
    output logic                carry,
    output logic [DATA_W-1:0]   regval,
    output logic [2*DATA_W-1:0] pair_out,
    output logic                reg_is_zero,
    output logic                take_branch
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_LD  = 4'h1, OP_XCH = 4'h2, OP_ADD = 4'h3,
        OP_SUB  = 4'h4, OP_INC = 4'h5, OP_LDM = 4'h6, OP_CLB = 4'h7,
        OP_RAL  = 4'h8, OP_RAR = 4'h9, OP_CMA = 4'hA, OP_TCC = 4'hB,
        OP_DAA  = 4'hC, OP_FIM = 4'hD, OP_WRP = 4'hE, OP_RSVD = 4'hF
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HI   = 2'd1,
        S_LO   = 2'd2
    } fim_state_t;

    fim_state_t        state;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [RI_W-1:0]   pair_idx;
    logic [RI_W-1:0]   even_idx;
    logic [RI_W-1:0]   odd_idx;
    logic [DATA_W:0]   add_sum;
    logic [DATA_W:0]   sub_sum;
    logic              cond;

    // Read side: live operand selects the register and the pair it belongs to;
    // a write in this cycle only becomes visible after the edge.
    assign even_idx    = {operand[RI_W-1:1], 1'b0};
    assign odd_idx     = {operand[RI_W-1:1], 1'b1};
    assign regval      = regs[operand];
    assign pair_out    = {regs[even_idx], regs[odd_idx]};
    assign reg_is_zero = (regval == '0);

    // Adders for ADD and SUB; carry=1 means "no borrow", so carry itself is
    // the carry-in of the subtract (acc - reg - borrow == acc + ~reg + carry).
    // NOTE: every signal in an always_comb is assigned on every path, otherwise a latch is inferred.
    always_comb begin
        add_sum = {1'b0, acc} + {1'b0, regval}  + {{DATA_W{1'b0}}, carry};
        sub_sum = {1'b0, acc} + {1'b0, ~regval} + {{DATA_W{1'b0}}, carry};
    end

`ifdef DATAPATH_DAA_EN
    logic [DATA_W:0] daa_sum;
    assign daa_sum = {1'b0, acc} + (DATA_W+1)'(6);
`endif

    // Branch condition from the operand's condition field and live flags.
    always_comb begin
        cond        = (operand[0] & test) | (operand[1] & carry) | (operand[2] & (acc == '0));
        take_branch = operand[3] ? ~cond : cond;
    end

    // Command acceptance, single-cycle ops and the FIM sequencer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            acc      <= '0;
            carry    <= 1'b1;
            pair_idx <= '0;
            // NOTE: the register file is cleared by reset because software relies on reading zeros, so it cannot map to a reset-less RAM.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values (XCH depends on this).
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        done <= 1'b1;
                        case (op_t'(op))
                            OP_LD:  acc <= regval;
                            OP_XCH: begin
                                acc            <= regval;
                                regs[operand]  <= acc;
                            end
                            OP_ADD: {carry, acc} <= add_sum;
                            OP_SUB: {carry, acc} <= sub_sum;
                            OP_INC: regs[operand] <= regval + DATA_W'(1);
                            OP_LDM: acc <= imm;
                            OP_CLB: begin
                                acc   <= '0;
                                carry <= 1'b0;
                            end
                            OP_RAL: {carry, acc} <= {acc, carry};
                            OP_RAR: {acc, carry} <= {carry, acc};
                            OP_CMA: acc <= ~acc;
                            OP_TCC: begin
                                acc   <= {{(DATA_W-1){1'b0}}, carry};
                                carry <= 1'b0;
                            end
`ifdef DATAPATH_DAA_EN
                            OP_DAA: begin
                                if ((acc > DATA_W'(9)) || carry) begin
                                    acc <= daa_sum[DATA_W-1:0];
                                    if (daa_sum[DATA_W]) begin
                                        carry <= 1'b1;
                                    end
                                end
                            end
`else
                            OP_DAA: ;
`endif
                            OP_FIM: begin
                                done     <= 1'b0;
                                busy     <= 1'b1;
                                pair_idx <= even_idx;
                                state    <= S_HI;
                            end
                            OP_WRP: regs[operand] <= acc;
                            default: ;
                        endcase
                    end
                end
                S_HI: begin
                    regs[pair_idx] <= data;
                    state          <= S_LO;
                end
                S_LO: begin
                    regs[{pair_idx[RI_W-1:1], 1'b1}] <= data;
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_wide.sv
// tb_datapath_wide: self-checking bench for datapath_wide with an
// arithmetic reference model of accumulator, carry and register file.
// Expectations for op C follow DATAPATH_DAA_EN as defined for the build.
module tb_datapath_wide;

    localparam int DATA_W   = 4;
    localparam int NUM_REGS = 16;
    localparam int RI_W     = 4;
    localparam int MOD      = 1 << DATA_W;

    logic                clock = 1'b0;
    logic                reset;
    logic                op_valid;
    logic [3:0]          op;
    logic [RI_W-1:0]     operand;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   data;
    logic                test;
    logic                busy;
    logic                done;
    logic [DATA_W-1:0]   acc;
    logic                carry;
    logic [DATA_W-1:0]   regval;
    logic [2*DATA_W-1:0] pair_out;
    logic                reg_is_zero;
    logic                take_branch;

    int checks = 0;
    int passed = 0;

    // Reference model state
    int m_acc;
    int m_carry;
    int m_regs [NUM_REGS];

    always #5 clock = ~clock;

    datapath_wide #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
        .clock       (clock),
        .reset       (reset),
        .op_valid    (op_valid),
        .op          (op),
        .operand     (operand),
        .imm         (imm),
        .data        (data),
        .test        (test),
        .busy        (busy),
        .done        (done),
        .acc         (acc),
        .carry       (carry),
        .regval      (regval),
        .pair_out    (pair_out),
        .reg_is_zero (reg_is_zero),
        .take_branch (take_branch)
    );

    task automatic model_reset();
        m_acc   = 0;
        m_carry = 1;
        foreach (m_regs[i]) m_regs[i] = 0;
    endtask

    task automatic model_op(input int o, input int idx, input int im);
        int r;
        int s;
        r = m_regs[idx];
        case (o)
            1: m_acc = r;
            2: begin m_regs[idx] = m_acc; m_acc = r; end
            3: begin s = m_acc + r + m_carry; m_acc = s % MOD; m_carry = (s >= MOD); end
            4: begin s = m_acc + (MOD - 1 - r) + m_carry; m_acc = s % MOD; m_carry = (s >= MOD); end
            5: m_regs[idx] = (r + 1) % MOD;
            6: m_acc = im;
            7: begin m_acc = 0; m_carry = 0; end
            8: begin s = m_acc * 2 + m_carry; m_carry = (s >= MOD); m_acc = s % MOD; end
            9: begin s = m_carry * MOD + m_acc; m_carry = s % 2; m_acc = s / 2; end
            10: m_acc = MOD - 1 - m_acc;
            11: begin m_acc = m_carry; m_carry = 0; end
            12: begin
`ifdef DATAPATH_DAA_EN
                if (m_acc > 9 || m_carry == 1) begin
                    s = m_acc + 6;
                    m_acc = s % MOD;
                    if (s >= MOD) m_carry = 1;
                end
`endif
            end
            14: m_regs[idx] = m_acc;
            default: ;
        endcase
    endtask

    // One-cycle command strobe; returns at the negedge after the accept edge.
    task automatic issue(input int o, input int idx, input int im);
        @(negedge clock);
        op_valid = 1'b1;
        op       = 4'(o);
        operand  = RI_W'(idx);
        imm      = DATA_W'(im);
        @(negedge clock);
        op_valid = 1'b0;
    endtask

    task automatic do_op(input int o, input int idx, input int im);
        issue(o, idx, im);
        model_op(o, idx, im);
    endtask

    task automatic test_reset();
        // A command presented during reset must be overridden by reset.
        reset = 1'b1; op_valid = 1'b1; op = 4'h6; imm = 4'h5;
        operand = '0; data = '0; test = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0; op_valid = 1'b0;
        model_reset();
        #1;
        checks++; if (acc !== 4'h0) $display("FAIL reset_acc got=%0h exp=0", acc); else passed++;
        checks++; if (carry !== 1'b1) $display("FAIL reset_carry got=%0b exp=1", carry); else passed++;
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done got=%0b%0b exp=00", busy, done); else passed++;
        for (int i = 0; i < NUM_REGS; i++) begin
            operand = RI_W'(i);
            #1;
            checks++; if (regval !== 4'h0 || reg_is_zero !== 1'b1) $display("FAIL reset_reg%0d got=%0h exp=0", i, regval); else passed++;
        end
    endtask

    task automatic test_basic_sequence();
        do_op(6, 0, 7);
        checks++; if (done !== 1'b1 || acc !== 4'h7) $display("FAIL ldm_done_acc got=%0b/%0h exp=1/7", done, acc); else passed++;
        @(negedge clock);
        checks++; if (done !== 1'b0) $display("FAIL done_single_pulse got=%0b exp=0", done); else passed++;
        do_op(14, 3, 0);
        checks++; if (done !== 1'b1) $display("FAIL wrp_done got=%0b exp=1", done); else passed++;
        do_op(1, 3, 0);
        checks++; if (acc !== 4'h7 || regval !== 4'h7 || carry !== 1'b1)
            $display("FAIL ld_seq got acc=%0h reg=%0h c=%0b exp 7/7/1", acc, regval, carry); else passed++;
        checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL ld_done got=%0b busy=%0b exp=1/0", done, busy); else passed++;
    endtask

    task automatic test_arith();
        do_op(6, 0, 8);  do_op(14, 1, 0);
        do_op(6, 0, 2);  do_op(14, 2, 0);
        do_op(7, 0, 0);  do_op(6, 0, 9);
        do_op(3, 1, 0);
        checks++; if (acc !== 4'h1 || carry !== 1'b1) $display("FAIL add got=%0h/%0b exp=1/1", acc, carry); else passed++;
        do_op(4, 2, 0);
        checks++; if (acc !== 4'hF || carry !== 1'b0) $display("FAIL sub got=%0h/%0b exp=f/0", acc, carry); else passed++;
    endtask

    task automatic test_daa();
        do_op(7, 0, 0); do_op(6, 0, 11); do_op(12, 0, 0);
`ifdef DATAPATH_DAA_EN
        checks++; if (acc !== 4'h1 || carry !== 1'b1) $display("FAIL daa got=%0h/%0b exp=1/1", acc, carry); else passed++;
`else
        checks++; if (acc !== 4'hB || carry !== 1'b0) $display("FAIL daa_nop got=%0h/%0b exp=b/0", acc, carry); else passed++;
`endif
        checks++; if (done !== 1'b1) $display("FAIL daa_done got=%0b exp=1", done); else passed++;
    endtask

    task automatic test_branch();
        logic [3:0] cf;
        logic       c;
        logic       exp_tb;
        do_op(7, 0, 0);
        @(negedge clock);
        test = 1'b0; operand = 4'b0110; #1;
        checks++; if (take_branch !== 1'b1) $display("FAIL branch_0110 got=%0b exp=1", take_branch); else passed++;
        operand = 4'b1110; #1;
        checks++; if (take_branch !== 1'b0) $display("FAIL branch_1110 got=%0b exp=0", take_branch); else passed++;
        for (int i = 0; i < 24; i++) begin
            do_op(6, 0, $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, MOD - 1));
            if ($urandom_range(0, 1) == 1) do_op(8, 0, 0);
            cf      = 4'($urandom_range(0, 15));
            test    = 1'($urandom_range(0, 1));
            operand = cf;
            #1;
            c      = (cf[0] && test) || (cf[1] && m_carry == 1) || (cf[2] && m_acc == 0);
            exp_tb = cf[3] ? !c : c;
            checks++; if (take_branch !== exp_tb)
                $display("FAIL branch_rand cf=%0h t=%0b got=%0b exp=%0b", cf, test, take_branch, exp_tb); else passed++;
        end
    endtask

    task automatic test_fim();
        int save_acc;
        int save_carry;
        do_op(6, 0, 5); do_op(14, 2, 0);
        save_acc = m_acc; save_carry = m_carry;
        issue(13, 5, 0);
        checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL fim_hi_busy got=%0b/%0b exp=1/0", busy, done); else passed++;
        // Mid-FIM command must be ignored; operand also shows the live read path.
        op_valid = 1'b1; op = 4'h6; imm = 4'h0; operand = 4'd2; data = 4'hA;
        #1;
        checks++; if (regval !== DATA_W'(m_regs[2])) $display("FAIL fim_live_read got=%0h exp=%0h", regval, m_regs[2]); else passed++;
        @(negedge clock);
        checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL fim_lo_busy got=%0b/%0b exp=1/0", busy, done); else passed++;
        data = 4'h3;
        @(negedge clock);
        op_valid = 1'b0;
        m_regs[4] = 10; m_regs[5] = 3;
        checks++; if (busy !== 1'b0 || done !== 1'b1) $display("FAIL fim_end got=%0b/%0b exp=0/1", busy, done); else passed++;
        operand = 4'd5; #1;
        checks++; if (pair_out !== 8'hA3 || regval !== 4'h3) $display("FAIL fim_pair got=%0h/%0h exp=a3/3", pair_out, regval); else passed++;
        checks++; if (acc !== DATA_W'(save_acc) || carry !== 1'(save_carry))
            $display("FAIL fim_acc_kept got=%0h/%0b exp=%0h/%0b", acc, carry, save_acc, save_carry); else passed++;
        @(negedge clock);
        checks++; if (done !== 1'b0 || acc !== DATA_W'(save_acc)) $display("FAIL fim_ignored_cmd got=%0b/%0h", done, acc); else passed++;
    endtask

    task automatic test_reset_mid_fim();
        issue(13, 4, 0);
        data = 4'h6; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL fim_abort got=%0b/%0b exp=0/0", busy, done); else passed++;
        @(negedge clock);
        operand = 4'd4; #1;
        checks++; if (done !== 1'b0 || pair_out !== 8'h00) $display("FAIL fim_abort_regs done=%0b pair=%0h exp=0/00", done, pair_out); else passed++;
    endtask

    task automatic test_back_to_back();
        do_op(6, 0, 14); do_op(14, 0, 0);
        @(negedge clock);
        op_valid = 1'b1; op = 4'h5; operand = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            model_op(5, 0, 0);
            checks++; if (done !== 1'b1) $display("FAIL b2b_done%0d got=%0b exp=1", i, done); else passed++;
        end
        op_valid = 1'b0; #1;
        checks++; if (regval !== DATA_W'(m_regs[0])) $display("FAIL b2b_inc got=%0h exp=%0h", regval, m_regs[0]); else passed++;
    endtask

    task automatic test_random();
        int o;
        int idx;
        int e;
        for (int i = 0; i < 150; i++) begin
            o = $urandom_range(0, 15);
            if (o == 13) o = 0;
            do_op(o, $urandom_range(0, NUM_REGS - 1), $urandom_range(0, MOD - 1));
            checks++; if (done !== 1'b1 || busy !== 1'b0 || acc !== DATA_W'(m_acc) || carry !== 1'(m_carry))
                $display("FAIL rand_op%0h got d=%0b b=%0b acc=%0h c=%0b exp acc=%0h c=%0b", o, done, busy, acc, carry, m_acc, m_carry); else passed++;
            idx = $urandom_range(0, NUM_REGS - 1);
            operand = RI_W'(idx);
            #1;
            e = (idx / 2) * 2;
            checks++; if (regval !== DATA_W'(m_regs[idx]) || reg_is_zero !== (m_regs[idx] == 0) ||
                          pair_out !== (2*DATA_W)'(m_regs[e] * MOD + m_regs[e + 1]))
                $display("FAIL rand_read r%0d got=%0h pair=%0h exp=%0h", idx, regval, pair_out, m_regs[idx]); else passed++;
        end
    endtask

    initial begin
        op_valid = 1'b0; op = '0; operand = '0; imm = '0; data = '0; test = 1'b0; reset = 1'b1;
        test_reset();
        test_basic_sequence();
        test_arith();
        test_daa();
        test_branch();
        test_fim();
        test_reset_mid_fim();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
